// File: rtl/slc3_pkg.sv
// Shared encodings for the SLC-3 control unit: state enum, opcodes, mux/ALU selects.
package slc3_pkg;

   typedef enum logic [4:0] {
      HALTED, FETCH_MAR, FETCH_RD, FETCH_IR, DECODE, EXEC_ALU, BR_CHK, BR_TAKE,
      JMP, JSR, LDR_MAR, LDR_RD, LDR_REG, STR_MAR, STR_MDR, STR_WR, PAUSE_HI, PAUSE_LO
   } state_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] ALUK_ADD  = 2'd0;
   localparam logic [1:0] ALUK_AND  = 2'd1;
   localparam logic [1:0] ALUK_NOT  = 2'd2;
   localparam logic [1:0] ALUK_PASS = 2'd3;

   localparam logic [1:0] PCMUX_INC   = 2'd0;
   localparam logic [1:0] PCMUX_BUS   = 2'd1;
   localparam logic [1:0] PCMUX_ADDER = 2'd2;

   localparam logic [1:0] ADDR2_ZERO  = 2'd0;
   localparam logic [1:0] ADDR2_OFF6  = 2'd1;
   localparam logic [1:0] ADDR2_OFF9  = 2'd2;
   localparam logic [1:0] ADDR2_OFF11 = 2'd3;

endpackage

// File: rtl/slc3_control.sv
// SLC-3 Moore control FSM: fetch/decode/execute sequencing with a stretched
// memory access (MEM_WAIT extra clocks) and a two-phase pause handshake.
module slc3_control
   import slc3_pkg::*;
#(
   parameter int MEM_WAIT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic       cont,
   input  logic [3:0] opcode,
   input  logic       ir_5,
   input  logic       ben,
   output logic       ld_mar,
   output logic       ld_mdr,
   output logic       ld_ir,
   output logic       ld_pc,
   output logic       ld_reg,
   output logic       ld_cc,
   output logic       ld_ben,
   output logic       ld_led,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] pcmux_sel,
   output logic       drmux_sel,
   output logic       sr1mux_sel,
   output logic       addr1mux_sel,
   output logic       mio_en,
   output logic       sr2mux_sel,
   output logic [1:0] addr2mux_sel,
   output logic [1:0] aluk,
   output logic       mem_oe_n,
   output logic       mem_we_n
);

   localparam int CW = $clog2(MEM_WAIT + 2);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          mem_state, mem_last;

   assign mem_state = (state == FETCH_RD) || (state == LDR_RD) || (state == STR_WR);
   assign mem_last  = (wait_cnt == CW'(MEM_WAIT));

   // Counter restarts on every state change, so each memory state begins at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= HALTED;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) wait_cnt <= '0;
         else if (mem_state)     wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_comb begin
      state_nxt    = state;
      ld_mar       = 1'b0;
      ld_mdr       = 1'b0;
      ld_ir        = 1'b0;
      ld_pc        = 1'b0;
      ld_reg       = 1'b0;
      ld_cc        = 1'b0;
      ld_ben       = 1'b0;
      ld_led       = 1'b0;
      GatePC       = 1'b0;
      GateMDR      = 1'b0;
      GateALU      = 1'b0;
      GateMARMUX   = 1'b0;
      pcmux_sel    = PCMUX_INC;
      drmux_sel    = 1'b0;
      sr1mux_sel   = 1'b0;
      addr1mux_sel = 1'b0;
      mio_en       = 1'b0;
      sr2mux_sel   = 1'b0;
      addr2mux_sel = ADDR2_ZERO;
      aluk         = ALUK_ADD;
      mem_oe_n     = 1'b1;
      mem_we_n     = 1'b1;
      case (state)
         HALTED:    if (run) state_nxt = FETCH_MAR;
         FETCH_MAR: begin
            GatePC = 1'b1; ld_mar = 1'b1; ld_pc = 1'b1; pcmux_sel = PCMUX_INC;
            state_nxt = FETCH_RD;
         end
         FETCH_RD: begin
            mio_en = 1'b1; mem_oe_n = 1'b0; ld_mdr = mem_last;
            if (mem_last) state_nxt = FETCH_IR;
         end
         FETCH_IR: begin
            GateMDR = 1'b1; ld_ir = 1'b1;
            state_nxt = DECODE;
         end
         DECODE: begin
            ld_ben = 1'b1;
            case (opcode)
               OP_BR:                  state_nxt = BR_CHK;
               OP_ADD, OP_AND, OP_NOT: state_nxt = EXEC_ALU;
               OP_JMP:                 state_nxt = JMP;
               OP_JSR:                 state_nxt = JSR;
               OP_LDR:                 state_nxt = LDR_MAR;
               OP_STR:                 state_nxt = STR_MAR;
               OP_PAUSE:               state_nxt = PAUSE_HI;
               default:                state_nxt = FETCH_MAR;
            endcase
         end
         EXEC_ALU: begin
            GateALU = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; sr2mux_sel = ir_5;
            if (opcode == OP_AND)      aluk = ALUK_AND;
            else if (opcode == OP_NOT) aluk = ALUK_NOT;
            state_nxt = FETCH_MAR;
         end
         BR_CHK:    state_nxt = ben ? BR_TAKE : FETCH_MAR;
         BR_TAKE: begin
            ld_pc = 1'b1; pcmux_sel = PCMUX_ADDER; addr2mux_sel = ADDR2_OFF9;
            state_nxt = FETCH_MAR;
         end
         JMP: begin
            ld_pc = 1'b1; pcmux_sel = PCMUX_BUS; GateALU = 1'b1; aluk = ALUK_PASS;
            state_nxt = FETCH_MAR;
         end
         JSR: begin
            GatePC = 1'b1; ld_reg = 1'b1; drmux_sel = 1'b1;
            ld_pc = 1'b1; pcmux_sel = PCMUX_ADDER; addr2mux_sel = ADDR2_OFF11;
            state_nxt = FETCH_MAR;
         end
         LDR_MAR, STR_MAR: begin
            GateMARMUX = 1'b1; ld_mar = 1'b1; addr1mux_sel = 1'b1; addr2mux_sel = ADDR2_OFF6;
            state_nxt = (state == LDR_MAR) ? LDR_RD : STR_MDR;
         end
         LDR_RD: begin
            mio_en = 1'b1; mem_oe_n = 1'b0; ld_mdr = mem_last;
            if (mem_last) state_nxt = LDR_REG;
         end
         LDR_REG: begin
            GateMDR = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
            state_nxt = FETCH_MAR;
         end
         STR_MDR: begin
            GateALU = 1'b1; aluk = ALUK_PASS; ld_mdr = 1'b1;
            state_nxt = STR_WR;
         end
         STR_WR: begin
            mem_we_n = 1'b0;
            if (mem_last) state_nxt = FETCH_MAR;
         end
         PAUSE_HI: begin
            ld_led = 1'b1;
            if (cont) state_nxt = PAUSE_LO;
         end
         PAUSE_LO:  if (!cont) state_nxt = FETCH_MAR;
         default:   state_nxt = HALTED;
      endcase
   end

endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control: expected per-cycle output vectors are
// queued as stimulus is planned and popped against the DUT after each edge.
module tb_slc3_control;

   localparam int MW = 2;

   typedef struct packed {
      logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben, ld_led;
      logic       gpc, gmdr, galu, gmarmux;
      logic [1:0] pcmux;
      logic       drmux, sr1mux, addr1mux, mio_en, sr2mux;
      logic [1:0] addr2mux, aluk;
      logic       oe_n, we_n;
   } outs_t;

   logic       clk = 1'b0, reset_n = 1'b0, run = 1'b0, cont = 1'b0, ir_5 = 1'b0, ben = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben, ld_led;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] pcmux_sel, addr2mux_sel, aluk;
   logic       drmux_sel, sr1mux_sel, addr1mux_sel, mio_en, sr2mux_sel, mem_oe_n, mem_we_n;

   int    checks = 0, errors = 0;
   outs_t exp_q[$];
   string tag_q[$];
   outs_t obs;

   always #5 clk = ~clk;

   slc3_control #(.MEM_WAIT(MW)) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .cont(cont), .opcode(opcode),
      .ir_5(ir_5), .ben(ben), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir),
      .ld_pc(ld_pc), .ld_reg(ld_reg), .ld_cc(ld_cc), .ld_ben(ld_ben), .ld_led(ld_led),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .pcmux_sel(pcmux_sel), .drmux_sel(drmux_sel), .sr1mux_sel(sr1mux_sel),
      .addr1mux_sel(addr1mux_sel), .mio_en(mio_en), .sr2mux_sel(sr2mux_sel),
      .addr2mux_sel(addr2mux_sel), .aluk(aluk), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
   );

   assign obs = '{ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben, ld_led,
                  GatePC, GateMDR, GateALU, GateMARMUX, pcmux_sel, drmux_sel, sr1mux_sel,
                  addr1mux_sel, mio_en, sr2mux_sel, addr2mux_sel, aluk, mem_oe_n, mem_we_n};

   function automatic outs_t idle();
      outs_t o = '0;
      o.oe_n = 1'b1; o.we_n = 1'b1;
      return o;
   endfunction

   function automatic outs_t e_fmar();
      outs_t o = idle();
      o.gpc = 1; o.ld_mar = 1; o.ld_pc = 1; o.pcmux = 2'd0;
      return o;
   endfunction

   function automatic outs_t e_rd(input logic last);
      outs_t o = idle();
      o.mio_en = 1; o.oe_n = 0; o.ld_mdr = last;
      return o;
   endfunction

   function automatic outs_t e_alu(input logic [1:0] k, input logic s2);
      outs_t o = idle();
      o.galu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = k; o.sr2mux = s2;
      return o;
   endfunction

   function automatic outs_t e_addr(); // LDR_MAR / STR_MAR
      outs_t o = idle();
      o.gmarmux = 1; o.ld_mar = 1; o.addr1mux = 1; o.addr2mux = 2'd1;
      return o;
   endfunction

   task automatic push(input string t, input outs_t e);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic check(input string t, input outs_t o, input outs_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", t, o, e);
      end
   endtask

   task automatic push_fetch();
      outs_t o;
      for (int i = 0; i <= MW; i++) push($sformatf("fetch_rd%0d", i), e_rd(i == MW));
      o = idle(); o.gmdr = 1; o.ld_ir = 1; push("fetch_ir", o);
      o = idle(); o.ld_ben = 1;           push("decode", o);
   endtask

   task automatic run_q();
      outs_t e;
      string t;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, obs, e);
      end
   endtask

   initial begin
      outs_t o;
      #12;
      check("reset_state", obs, idle());
      @(negedge clk); reset_n = 1'b1;
      push("halted_idle", idle()); run_q();
      run = 1'b1; push("fmar_after_run", e_fmar()); run_q(); run = 1'b0;

      // ADD imm, AND reg, NOT
      opcode = 4'b0001; ir_5 = 1'b1;
      push_fetch(); push("exec_add", e_alu(2'd0, 1'b1)); push("fmar", e_fmar()); run_q();
      opcode = 4'b0101; ir_5 = 1'b0;
      push_fetch(); push("exec_and", e_alu(2'd1, 1'b0)); push("fmar", e_fmar()); run_q();
      opcode = 4'b1001; ir_5 = 1'b1;
      push_fetch(); push("exec_not", e_alu(2'd2, 1'b1)); push("fmar", e_fmar()); run_q();

      // BR not taken, then taken
      opcode = 4'b0000; ben = 1'b0;
      push_fetch(); push("br_chk0", idle()); push("br_nt_fmar", e_fmar()); run_q();
      ben = 1'b1;
      o = idle(); o.ld_pc = 1; o.pcmux = 2'd2; o.addr2mux = 2'd2;
      push_fetch(); push("br_chk1", idle()); push("br_take", o); push("fmar", e_fmar()); run_q();
      ben = 1'b0;

      // JMP, JSR
      opcode = 4'b1100;
      o = idle(); o.ld_pc = 1; o.pcmux = 2'd1; o.galu = 1; o.aluk = 2'd3;
      push_fetch(); push("jmp", o); push("fmar", e_fmar()); run_q();
      opcode = 4'b0100;
      o = idle(); o.gpc = 1; o.ld_reg = 1; o.drmux = 1; o.ld_pc = 1; o.pcmux = 2'd2; o.addr2mux = 2'd3;
      push_fetch(); push("jsr", o); push("fmar", e_fmar()); run_q();

      // LDR
      opcode = 4'b0110;
      push_fetch(); push("ldr_mar", e_addr());
      for (int i = 0; i <= MW; i++) push($sformatf("ldr_rd%0d", i), e_rd(i == MW));
      o = idle(); o.gmdr = 1; o.ld_reg = 1; o.ld_cc = 1;
      push("ldr_reg", o); push("fmar", e_fmar()); run_q();

      // STR: mem_we_n low exactly MW+1 cycles, mio_en 0 in STR_MDR
      opcode = 4'b0111;
      push_fetch(); push("str_mar", e_addr());
      o = idle(); o.galu = 1; o.aluk = 2'd3; o.ld_mdr = 1; push("str_mdr", o);
      o = idle(); o.we_n = 0;
      for (int i = 0; i <= MW; i++) push($sformatf("str_wr%0d", i), o);
      push("str_done_fmar", e_fmar()); run_q();

      // NOP with run held high (ignored outside HALTED)
      opcode = 4'b1111; run = 1'b1;
      push_fetch(); push("nop_fmar", e_fmar()); run_q(); run = 1'b0;

      // PAUSE with cont held high 10 cycles
      opcode = 4'b1101; cont = 1'b1;
      o = idle(); o.ld_led = 1;
      push_fetch(); push("pause_hi", o);
      for (int i = 0; i < 9; i++) push($sformatf("pause_lo_held%0d", i), idle());
      run_q(); cont = 1'b0;
      push("pause_exit_fmar", e_fmar()); run_q();

      // PAUSE waiting for cont to rise
      o = idle(); o.ld_led = 1;
      push_fetch(); push("pause_wait0", o); push("pause_wait1", o); push("pause_wait2", o);
      run_q(); cont = 1'b1;
      push("pause_lo0", idle()); push("pause_lo1", idle()); run_q(); cont = 1'b0;
      push("pause2_fmar", e_fmar()); run_q();

      // Reset during FETCH_RD: immediate HALTED, counter cleared
      push("rd_before_rst", e_rd(1'b0)); run_q();
      reset_n = 1'b0; #1;
      check("rst_in_fetch_rd", obs, idle());
      @(negedge clk); reset_n = 1'b1;
      push("halted_after_rst", idle()); run_q();
      run = 1'b1; push("fmar_rerun", e_fmar()); run_q(); run = 1'b0;

      // Reset mid STR_WR releases mem_we_n immediately
      opcode = 4'b0111;
      push_fetch(); push("str_mar2", e_addr());
      o = idle(); o.galu = 1; o.aluk = 2'd3; o.ld_mdr = 1; push("str_mdr2", o);
      o = idle(); o.we_n = 0; push("str_wr_pre_rst", o);
      run_q();
      reset_n = 1'b0; #1;
      check("rst_in_str_wr", obs, idle());
      @(negedge clk); reset_n = 1'b1;
      push("halted_final", idle()); run_q();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/slc3_control.md
SLC3_CONTROL -- requirements
Module: slc3_control

Interface
REQ-001 Parameter MEM_WAIT, default 2, number of extra clocks a memory read/write access is held.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 run  input  1  start request from HALTED.
REQ-005 cont  input  1  continue request; used in PAUSE.
REQ-006 opcode  input  4  IR[15:12] from the datapath IR register.
REQ-007 ir_5  input  1  IR[5]; selects immediate vs register second operand.
REQ-008 ben  input  1  branch-enable flag from the datapath.
REQ-009 ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben, ld_led  output  1 each  datapath register loads.
REQ-010 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle.
REQ-011 pcmux_sel  output  2  0=PC+1, 1=bus, 2=adder.
REQ-012 drmux_sel, sr1mux_sel, addr1mux_sel, mio_en  output  1 each  datapath mux selects; mio_en=1 routes mem_rdata into MDR.
REQ-013 sr2mux_sel  output  1  0=register, 1=sext imm5; equals ir_5 in EXEC_ALU.
REQ-014 addr2mux_sel, aluk  output  2 each  address-offset and ALU-op selects.
REQ-015 mem_oe_n, mem_we_n  output  1 each  active-low SRAM output/write enables.

Function
REQ-016 States: HALTED, FETCH_MAR, FETCH_RD, FETCH_IR, DECODE, EXEC_ALU, BR_CHK, BR_TAKE, JMP, JSR, LDR_MAR, LDR_RD, LDR_REG, STR_MAR, STR_MDR, STR_WR, PAUSE_HI, PAUSE_LO.
REQ-017 Outputs are a combinational function of state (Moore); every output not named for a state is 0, except mem_oe_n/mem_we_n, which are 1.
REQ-018 HALTED: all loads low; to FETCH_MAR when run=1, else stay.
REQ-019 FETCH_MAR: GatePC, ld_mar, ld_pc, pcmux_sel=0; next FETCH_RD.
REQ-020 FETCH_RD: mio_en=1, mem_oe_n=0; held MEM_WAIT+1 clocks by an internal counter; ld_mdr=1 on the last clock only; next FETCH_IR.
REQ-021 FETCH_IR: GateMDR, ld_ir; next DECODE.
REQ-022 DECODE: ld_ben; dispatch on opcode: 0000 to BR_CHK; 0001/0101/1001 (ADD/AND/NOT) to EXEC_ALU; 1100 to JMP; 0100 to JSR; 0110 to LDR_MAR; 0111 to STR_MAR; 1101 to PAUSE_HI; any other opcode is a NOP and goes to FETCH_MAR.
REQ-023 EXEC_ALU: GateALU, ld_reg, ld_cc; aluk=0 ADD, 1 AND, 2 NOT; then FETCH_MAR.
REQ-024 BR_CHK: to BR_TAKE if ben=1, else FETCH_MAR; BR_TAKE: ld_pc, pcmux_sel=2, addr2mux_sel=2 (off9); then FETCH_MAR.
REQ-025 JMP: ld_pc, pcmux_sel=1, GateALU with aluk=3 (pass SR1); JSR: GatePC, ld_reg, drmux_sel=1 (R7), ld_pc, pcmux_sel=2, addr2mux_sel=3 (off11); both then FETCH_MAR.
REQ-026 LDR_MAR/STR_MAR: GateMARMUX, ld_mar, addr1mux_sel=1, addr2mux_sel=1 (off6).
REQ-027 LDR_RD: behaves like FETCH_RD (MEM_WAIT+1 clocks); then LDR_REG: GateMDR, ld_reg, ld_cc; then FETCH_MAR.
REQ-028 STR_MDR: GateALU, aluk=3, sr1mux_sel=0, ld_mdr, mio_en=0; STR_WR: mem_we_n=0 for MEM_WAIT+1 clocks; then FETCH_MAR.
REQ-029 PAUSE_HI: ld_led; hold until cont=1, then PAUSE_LO; PAUSE_LO: hold until cont=0, then FETCH_MAR. A single long cont press therefore advances exactly one pause.
REQ-030 run is ignored in every state except HALTED; the block never returns to HALTED except through reset.
REQ-031 Wait counter is cleared on entry to every memory state; MEM_WAIT=0 gives single-cycle access.

Reset
REQ-032 reset_n=0 forces state HALTED and wait counter 0 immediately, from any state; outputs then take their HALTED values (all loads and gates 0, mem_oe_n=mem_we_n=1).
REQ-033 Reset mid-write (STR_WR) deasserts mem_we_n asynchronously; no partial-cycle load is issued.

Structure
REQ-034 State enum, opcode constants, aluk/pcmux/addr2mux encodings live in shared package slc3_pkg.
REQ-035 Single module; wait counter inline, width $clog2(MEM_WAIT+2).

Verification
REQ-036 Reset then run=1 for 1 cycle -> FETCH_MAR next cycle; with MEM_WAIT=2, ld_ir pulses exactly 5 cycles after run sampled.
REQ-037 opcode=0001, ir_5=1 -> EXEC_ALU with aluk=0, sr2mux_sel=1, ld_reg=ld_cc=1 for one cycle, then FETCH_MAR.
REQ-038 opcode=0000: ben=0 -> no ld_pc after DECODE; ben=1 -> one ld_pc with pcmux_sel=2.
REQ-039 opcode=0111 -> mem_we_n low exactly MEM_WAIT+1 cycles, and mio_en=0 during STR_MDR.
REQ-040 opcode=1101 with cont held high 10 cycles -> one pass to FETCH_MAR only after cont falls; reset_n pulsed low during FETCH_RD -> HALTED, all loads 0.
